// File: rtl/regfile_write_arbiter.sv
// Single write port of the 32x32 register bank: zeroes registers 1..31 after reset
// or on request, then shares the port among N_REQ requesters with round-robin valid/ready.
module regfile_write_arbiter #(
   parameter int N_REQ  = 3,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear_req,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*ADDR_W-1:0] req_rd,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    wr_en,
   output logic [ADDR_W-1:0]       wr_rd,
   output logic [DATA_W-1:0]       wr_data,
   output logic [2:0]              wr_src,
   output logic                    busy
);

   localparam int PW = $clog2(N_REQ);

   typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  cnt_q, cnt_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic               wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]  wr_rd_q, wr_rd_d;
   logic [DATA_W-1:0]  wr_data_q, wr_data_d;
   logic [2:0]         wr_src_q, wr_src_d;

   logic               hi_found, lo_found, found, accept;
   logic [PW-1:0]      hi_idx, lo_idx, grant;
   logic [ADDR_W-1:0]  sel_rd;
   logic [DATA_W-1:0]  sel_data;

   // Lowest valid index at or above ptr wins; otherwise wrap to lowest valid overall.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            lo_found = 1'b1;
            lo_idx   = PW'(i);
            if (PW'(i) >= ptr_q) begin
               hi_found = 1'b1;
               hi_idx   = PW'(i);
            end
         end
      end
      found  = hi_found | lo_found;
      grant  = hi_found ? hi_idx : lo_idx;
      accept = found && (state_q == S_RUN) && !clear_req;
      req_ready = '0;
      if (accept) begin
         req_ready[grant] = 1'b1;
      end
   end

   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (PW'(i) == grant) begin
            sel_rd   = req_rd[i*ADDR_W +: ADDR_W];
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      wr_en_d   = 1'b0;
      wr_rd_d   = wr_rd_q;
      wr_data_d = wr_data_q;
      wr_src_d  = wr_src_q;
      unique case (state_q)
         S_CLEAR: begin
            if (cnt_q != '0) begin
               wr_en_d   = 1'b1;
               wr_rd_d   = cnt_q;
               wr_data_d = '0;
               wr_src_d  = '0;
               cnt_d     = cnt_q + 1'b1;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (clear_req) begin
               // The request edge itself emits the first clear write.
               state_d   = S_CLEAR;
               wr_en_d   = 1'b1;
               wr_rd_d   = ADDR_W'(1);
               wr_data_d = '0;
               wr_src_d  = '0;
               cnt_d     = ADDR_W'(2);
            end else if (accept) begin
               wr_en_d   = (sel_rd != '0);
               wr_rd_d   = sel_rd;
               wr_data_d = sel_data;
               wr_src_d  = 3'(grant);
               ptr_d     = (grant == PW'(N_REQ - 1)) ? '0 : grant + 1'b1;
            end
         end
         default: state_d = S_CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_CLEAR;
         cnt_q     <= ADDR_W'(1);
         ptr_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_rd_q   <= '0;
         wr_data_q <= '0;
         wr_src_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         wr_en_q   <= wr_en_d;
         wr_rd_q   <= wr_rd_d;
         wr_data_q <= wr_data_d;
         wr_src_q  <= wr_src_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_rd   = wr_rd_q;
   assign wr_data = wr_data_q;
   assign wr_src  = wr_src_q;
   assign busy    = (state_q == S_CLEAR);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a round-robin reference model
// predicts grants and queues expected bank writes; a monitor pops and compares.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

   localparam int N  = 3;
   localparam int DW = 32;
   localparam int AW = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic              clear_req;
   logic [N-1:0]      req_valid;
   logic [N*AW-1:0]   req_rd;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      req_ready;
   logic              wr_en;
   logic [AW-1:0]     wr_rd;
   logic [DW-1:0]     wr_data;
   logic [2:0]        wr_src;
   logic              busy;

   regfile_write_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .clear_req (clear_req),
      .req_valid (req_valid),
      .req_rd    (req_rd),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wr_en     (wr_en),
      .wr_rd     (wr_rd),
      .wr_data   (wr_data),
      .wr_src    (wr_src),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
      logic [2:0]    src;
   } wr_t;

   wr_t          exp_q[$];
   int           checks = 0;
   int           errors = 0;
   int           m_ptr = 0;
   bit           m_clear = 1'b1;
   int           m_left = 31;
   logic [N-1:0] m_acc = '0;
   logic [N-1:0] last_ready = '0;
   logic [DW-1:0] dut_bank [32];

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every bank write must match the oldest predicted write.
   initial begin
      wr_t e;
      forever begin
         @(posedge clk);
         #3;
         if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wr_unexpected actual rd=%0d data=%0h required none",
                        wr_rd, wr_data);
            end else begin
               e = exp_q.pop_front();
               check("wr_rd", 64'(wr_rd), 64'(e.rd));
               check("wr_data", 64'(wr_data), 64'(e.data));
               check("wr_src", 64'(wr_src), 64'(e.src));
            end
            dut_bank[wr_rd] = wr_data;
         end
      end
   end

   task automatic push_clear();
      for (int k = 1; k < 32; k++) begin
         exp_q.push_back(wr_t'{AW'(k), '0, 3'd0});
      end
   endtask

   task automatic set_req(input int i, input logic v,
                          input logic [AW-1:0] rd, input logic [DW-1:0] d);
      req_valid[i]          = v;
      req_rd[i*AW +: AW]    = rd;
      req_data[i*DW +: DW]  = d;
   endtask

   task automatic do_reset(input int n);
      reset     = 1'b1;
      clear_req = 1'b0;
      req_valid = '0;
      m_acc     = '0;
      @(posedge clk);
      #1;
      exp_q.delete();
      repeat (n - 1) begin
         @(posedge clk);
         #1;
      end
      reset   = 1'b0;
      m_clear = 1'b1;
      m_left  = 31;
      m_ptr   = 0;
      push_clear();
   endtask

   // One cycle: check ready/busy against the model, then advance the model.
   task automatic step();
      int g;
      logic [N-1:0] exp_rdy;
      @(negedge clk);
      g = -1;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (g < 0 && req_valid[i]) g = i;
      end
      exp_rdy = '0;
      if (!m_clear && !clear_req && g >= 0) exp_rdy = N'(1) << g;
      check("busy", 64'(busy), 64'(m_clear));
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      last_ready = req_ready;
      m_acc = '0;
      if (m_clear) begin
         if (m_left == 0) m_clear = 1'b0;
         else m_left--;
      end else if (clear_req) begin
         m_clear = 1'b1;
         m_left  = 30;
         push_clear();
      end else if (g >= 0) begin
         m_acc = N'(1) << g;
         if (req_rd[g*AW +: AW] != '0) begin
            exp_q.push_back(wr_t'{req_rd[g*AW +: AW], req_data[g*DW +: DW], 3'(g)});
         end
         m_ptr = (g + 1) % N;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rand_drive(input int clr_odds);
      for (int i = 0; i < N; i++) begin
         if (m_acc[i]) req_valid[i] = 1'b0;
         if (!req_valid[i] && ($urandom % 3) != 0) begin
            set_req(i, 1'b1, AW'($urandom_range(0, 31)), DW'($urandom));
         end
      end
      clear_req = (clr_odds > 0) && (($urandom % clr_odds) == 0);
   endtask

   initial begin
      reset     = 1'b1;
      clear_req = 1'b0;
      req_valid = '0;
      req_rd    = '0;
      req_data  = '0;
      dut_bank[0] = '0;

      // Reset and initial clear sequence, then idle.
      do_reset(2);
      repeat (34) step();
      check("clear_drained", 64'(exp_q.size()), 64'd0);
      check("idle_wr_en", 64'(wr_en), 64'd0);

      // Single write from requester 0.
      set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
      step();
      check("single_ready", 64'(last_ready), 64'b001);
      req_valid = '0;
      step();
      step();
      check("bank_r5", 64'(dut_bank[5]), 64'hDEADBEEF);

      // All three continuously valid from ptr=0.
      do_reset(2);
      repeat (33) step();
      for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 10), DW'($urandom));
      for (int c = 0; c < 6; c++) begin
         step();
         check("rr_seq", 64'(last_ready), 64'(N'(1) << (c % N)));
         for (int i = 0; i < N; i++) begin
            if (m_acc[i]) set_req(i, 1'b1, AW'($urandom_range(1, 31)), DW'($urandom));
         end
      end

      // Accepted write to r0 is dropped but still advances the pointer.
      req_valid = '0;
      set_req(1, 1'b1, 5'd0, 32'h1234);
      step();
      check("rd0_ready", 64'(last_ready), 64'b010);
      req_valid = '0;
      step();
      check("rd0_no_wr", 64'(wr_en), 64'd0);
      for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 20), DW'($urandom));
      step();
      check("ptr_after_rd0", 64'(last_ready), 64'b100);

      // Streaming interrupted by a clear request.
      repeat (10) begin
         rand_drive(0);
         step();
      end
      rand_drive(0);
      clear_req = 1'b1;
      step();
      check("clr_req_ready", 64'(last_ready), 64'd0);
      clear_req = 1'b0;
      repeat (45) begin
         rand_drive(0);
         step();
      end

      // Reset in the middle of a clear.
      do_reset(2);
      repeat (17) step();
      check("clr_at_17", 64'(wr_rd), 64'd17);
      do_reset(1);
      repeat (34) step();
      check("clear_restart_drained", 64'(exp_q.size()), 64'd0);

      // Random traffic with occasional clears and resets.
      for (int c = 0; c < 1500; c++) begin
         if (($urandom % 400) == 0) begin
            do_reset(1 + int'($urandom % 2));
         end else begin
            rand_drive(60);
         end
         step();
      end
      req_valid = '0;
      clear_req = 1'b0;
      repeat (40) step();
      check("final_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
